// File: rtl/pl_pkg.sv
// Payload widths and field offsets for the stage registers between F/D, D/E, E/M and M/W.
// Each stage packs and unpacks its bundle with these offsets where it instantiates pl_reg_elastic.
package pl_pkg;

    localparam int FD_PAYLOAD_W = 96;   // PC, Instr, PCPlus4
    localparam int DE_PAYLOAD_W = 211;
    localparam int EM_PAYLOAD_W = 108;  // RegWrite, ResultSrc, MemWrite, ALUResult, WriteData, Rd, PCPlus4, Funct3
    localparam int MW_PAYLOAD_W = 104;  // RegWrite, ResultSrc, ALUResult, ReadData, Rd, PCPlus4

    // D/E bundle, RegWrite at the MSB down to selectauipc at bit 0; each LSB chains from the field below.
    localparam int DE_SELECTAUIPC_LSB = 0;
    localparam int DE_LUI_LSB         = DE_SELECTAUIPC_LSB + 1;
    localparam int DE_JALR_LSB        = DE_LUI_LSB + 1;
    localparam int DE_STORETYPE_LSB   = DE_JALR_LSB + 1;
    localparam int DE_LOADTYPE_LSB    = DE_STORETYPE_LSB + 2;
    localparam int DE_FUNCT7_LSB      = DE_LOADTYPE_LSB + 3;
    localparam int DE_OP_LSB          = DE_FUNCT7_LSB + 7;
    localparam int DE_FUNCT3_LSB      = DE_OP_LSB + 7;
    localparam int DE_PCPLUS4_LSB     = DE_FUNCT3_LSB + 3;
    localparam int DE_IMMEXT_LSB      = DE_PCPLUS4_LSB + 32;
    localparam int DE_RD_LSB          = DE_IMMEXT_LSB + 32;
    localparam int DE_RS2_LSB         = DE_RD_LSB + 5;
    localparam int DE_RS1_LSB         = DE_RS2_LSB + 5;
    localparam int DE_PC_LSB          = DE_RS1_LSB + 5;
    localparam int DE_RD2_LSB         = DE_PC_LSB + 32;
    localparam int DE_RD1_LSB         = DE_RD2_LSB + 32;
    localparam int DE_ALUSRC_LSB      = DE_RD1_LSB + 32;
    localparam int DE_ALUCONTROL_LSB  = DE_ALUSRC_LSB + 1;
    localparam int DE_BRANCH_LSB      = DE_ALUCONTROL_LSB + 4;
    localparam int DE_JUMP_LSB        = DE_BRANCH_LSB + 1;
    localparam int DE_MEMWRITE_LSB    = DE_JUMP_LSB + 1;
    localparam int DE_RESULTSRC_LSB   = DE_MEMWRITE_LSB + 1;
    localparam int DE_REGWRITE_LSB    = DE_RESULTSRC_LSB + 2;   // = 210, top bit of a 211-bit bundle

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } pl_state_e;

    // The skid slot is only ever filled while main is occupied, so skid_v alone marks "full".
    function automatic pl_state_e pl_state(input logic main_v, input logic skid_v);
        if (skid_v)
            return ST_FULL;
        else if (main_v)
            return ST_MAIN;
        return ST_EMPTY;
    endfunction

endpackage

// File: rtl/pl_reg_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake with a two-entry skid buffer.
// in_ready and out_* come straight from flops, so out_ready has no combinational path to in_ready.
module pl_reg_elastic
    import pl_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             acc;
    logic             pop;

    assign acc = in_valid & ~skid_v_q;
    assign pop = main_v_q & out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (reset || flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            if (ZERO_ON_FLUSH) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case (pl_state(main_v_q, skid_v_q))
                ST_EMPTY: begin
                    if (acc) begin
                        main_v_d    = 1'b1;
                        main_data_d = in_data;
                    end
                end
                ST_MAIN: begin
                    if (pop && acc) begin
                        main_data_d = in_data;
                    end else if (pop) begin
                        main_v_d = 1'b0;
                    end else if (acc) begin
                        // Downstream is stalled: park the new item behind main.
                        skid_v_d    = 1'b1;
                        skid_data_d = in_data;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_data_d = skid_data_q;
                        skid_v_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    // Payload clearing on reset/flush is already folded into the _d terms when ZERO_ON_FLUSH is set.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_pl_reg_elastic.sv
// Directed and randomised checks of pl_reg_elastic in three configurations
// (32-bit zeroing, 8-bit non-zeroing, 211-bit D/E width against a reference queue).
module tb_pl_reg_elastic;
    import pl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 32-bit, ZERO_ON_FLUSH = 1
    logic        flush_a = 0, in_valid_a = 0, out_ready_a = 0;
    logic [31:0] in_data_a = '0;
    logic        in_ready_a, out_valid_a;
    logic [31:0] out_data_a;
    logic [1:0]  occ_a;

    // 8-bit, ZERO_ON_FLUSH = 0
    logic        flush_b = 0, in_valid_b = 0, out_ready_b = 0;
    logic [7:0]  in_data_b = '0;
    logic        in_ready_b, out_valid_b;
    logic [7:0]  out_data_b;
    logic [1:0]  occ_b;

    // D/E width, ZERO_ON_FLUSH = 1
    logic                    flush_c = 0, in_valid_c = 0, out_ready_c = 0;
    logic [DE_PAYLOAD_W-1:0] in_data_c = '0;
    logic                    in_ready_c, out_valid_c;
    logic [DE_PAYLOAD_W-1:0] out_data_c;
    logic [1:0]              occ_c;

    pl_reg_elastic #(.WIDTH(32), .ZERO_ON_FLUSH(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .occupancy(occ_a)
    );

    pl_reg_elastic #(.WIDTH(8), .ZERO_ON_FLUSH(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .occupancy(occ_b)
    );

    pl_reg_elastic #(.WIDTH(DE_PAYLOAD_W), .ZERO_ON_FLUSH(1'b1)) u_dut_c (
        .clk(clk), .reset(reset), .flush(flush_c),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
        .occupancy(occ_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] d,
                         input logic rdy, input logic [1:0] occ);
        $display("[%0t] %s: out_valid=%0b out_data=%0h in_ready=%0b occ=%0d",
                 $time, tag, out_valid_a, out_data_a, in_ready_a, occ_a);
        chk({tag, ".out_valid"}, 256'(out_valid_a), 256'(v));
        if (v) chk({tag, ".out_data"}, 256'(out_data_a), 256'(d));
        chk({tag, ".in_ready"}, 256'(in_ready_a), 256'(rdy));
        chk({tag, ".occupancy"}, 256'(occ_a), 256'(occ));
    endtask

    logic [DE_PAYLOAD_W-1:0] ref_q[$];
    logic [DE_PAYLOAD_W-1:0] held;
    logic [223:0]            rnd;
    logic                    acc, pop, stalled;
    int                      pops;

    initial begin
        // 1. Reset with a valid input present: the input must be discarded.
        reset = 1'b1;
        in_valid_a = 1'b1;
        in_data_a = 32'hDEAD_BEEF;
        tick();
        tick();
        reset = 1'b0;
        in_valid_a = 1'b0;
        $display("[%0t] reset released", $time);
        chk("reset.out_valid", 256'(out_valid_a), 256'(1'b0));
        chk("reset.out_data", 256'(out_data_a), 256'(32'h0));
        chk("reset.in_ready", 256'(in_ready_a), 256'(1'b1));
        chk("reset.occupancy", 256'(occ_a), 256'(2'd0));

        // 2. Streaming at full rate.
        out_ready_a = 1'b1;
        in_valid_a = 1'b1;
        in_data_a = 32'h1; tick(); chk_a("stream1", 1'b1, 32'h1, 1'b1, 2'd1);
        in_data_a = 32'h2; tick(); chk_a("stream2", 1'b1, 32'h2, 1'b1, 2'd1);
        in_data_a = 32'h3; tick(); chk_a("stream3", 1'b1, 32'h3, 1'b1, 2'd1);
        in_valid_a = 1'b0;
        tick(); chk_a("stream_drain", 1'b0, 32'h0, 1'b1, 2'd0);

        // 3. Backpressure fills both slots, then drains in order.
        out_ready_a = 1'b0;
        in_valid_a = 1'b1;
        in_data_a = 32'hA; tick(); chk_a("bp_pushA", 1'b1, 32'hA, 1'b1, 2'd1);
        in_data_a = 32'hB; tick(); chk_a("bp_pushB", 1'b1, 32'hA, 1'b0, 2'd2);
        in_data_a = 32'hC; tick(); chk_a("bp_holdC", 1'b1, 32'hA, 1'b0, 2'd2);
        out_ready_a = 1'b1;
        tick(); chk_a("bp_popA", 1'b1, 32'hB, 1'b1, 2'd1);
        tick(); chk_a("bp_popB", 1'b1, 32'hC, 1'b1, 2'd1);
        in_valid_a = 1'b0;
        tick(); chk_a("bp_popC", 1'b0, 32'h0, 1'b1, 2'd0);

        // 4. Flush while full, with a concurrent valid input.
        out_ready_a = 1'b0;
        in_valid_a = 1'b1;
        in_data_a = 32'hA; tick();
        in_data_a = 32'hB; tick(); chk_a("fl_full", 1'b1, 32'hA, 1'b0, 2'd2);
        flush_a = 1'b1;
        in_data_a = 32'hC; tick();
        flush_a = 1'b0;
        in_valid_a = 1'b0;
        chk_a("fl_empty", 1'b0, 32'h0, 1'b1, 2'd0);
        chk("fl_zero_data", 256'(out_data_a), 256'(32'h0));
        out_ready_a = 1'b1;
        tick(); chk_a("fl_noC", 1'b0, 32'h0, 1'b1, 2'd0);

        // 5. Non-zeroing flush keeps the payload but clears valid.
        in_valid_b = 1'b1;
        in_data_b = 8'h5A;
        tick();
        in_valid_b = 1'b0;
        $display("[%0t] nz_push: out_valid=%0b out_data=%0h", $time, out_valid_b, out_data_b);
        chk("nz_push.out_valid", 256'(out_valid_b), 256'(1'b1));
        chk("nz_push.out_data", 256'(out_data_b), 256'(8'h5A));
        flush_b = 1'b1;
        tick();
        flush_b = 1'b0;
        $display("[%0t] nz_flush: out_valid=%0b out_data=%0h", $time, out_valid_b, out_data_b);
        chk("nz_flush.out_valid", 256'(out_valid_b), 256'(1'b0));
        chk("nz_flush.out_data", 256'(out_data_b), 256'(8'h5A));
        chk("nz_flush.occupancy", 256'(occ_b), 256'(2'd0));

        // 6. Random traffic on the D/E-width instance against a reference queue.
        pops = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid_c  = ($urandom_range(0, 99) < 70);
            out_ready_c = ($urandom_range(0, 99) < 60);
            flush_c     = ($urandom_range(0, 99) < 5);
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom()};
            in_data_c = rnd[DE_PAYLOAD_W-1:0];
            #1;
            acc     = in_valid_c && (ref_q.size() < 2);
            pop     = out_valid_c && out_ready_c;
            stalled = out_valid_c && !out_ready_c && !flush_c;
            held    = out_data_c;
            if (pop) begin
                pops++;
                $display("[%0t] rnd pop #%0d data=%0h", $time, pops, out_data_c);
                chk("rnd.order", 256'(out_data_c), 256'(ref_q[0]));
            end
            tick();
            if (flush_c) begin
                ref_q.delete();
            end else begin
                if (pop) void'(ref_q.pop_front());
                if (acc) ref_q.push_back(in_data_c);
            end
            chk("rnd.occupancy", 256'(occ_c), 256'(ref_q.size()));
            chk("rnd.out_valid", 256'(out_valid_c), 256'(ref_q.size() != 0));
            chk("rnd.in_ready", 256'(in_ready_c), 256'(ref_q.size() != 2));
            if (stalled) chk("rnd.stable", 256'(out_data_c), 256'(held));
            if (flush_c) chk("rnd.flush_zero", 256'(out_data_c), 256'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pl_reg_elastic.md
Name: pl_reg_elastic

Overview:
Parametrised, elastic pipeline-stage register for the RISC-V pipeline, replacing the fixed-field, always-enabled stage registers. It carries an opaque WIDTH-bit payload with a valid/ready handshake and a 2-entry skid buffer. This gives full throughput with no combinational path from out_ready to in_ready, plus a synchronous flush for branch/jump squash. One instance sits between each pair of pipeline stages (F/D, D/E, E/M, M/W).

Parameters:
WIDTH, 32, payload width in bits (D/E instance uses DE_PAYLOAD_W = 211)
ZERO_ON_FLUSH, 1, 1 = payload registers forced to 0 on flush/reset (bubble = all-zero control); 0 = payload left unchanged, only valid bits cleared

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous squash of all held entries (hazard unit clr)
in_valid  input  1  upstream stage presents a payload
in_ready  output  1  this block can accept a payload this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid payload
out_ready  input  1  downstream stage consumes out_data this cycle
out_data  output  WIDTH  payload to downstream stage
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Storage: main slot (main_v, main_d) drives out_valid/out_data directly from flops; skid slot (skid_v, skid_d) holds overflow.
- in_ready = ~skid_v, a pure flop output. out_valid = main_v; out_data = main_d; occupancy = main_v + skid_v.
- acc = in_valid & in_ready; pop = main_v & out_ready.
- Per-edge update, evaluated in priority order:
  1. reset or flush: main_v = 0, skid_v = 0. If ZERO_ON_FLUSH, main_d = 0 and skid_d = 0. in_data in the same cycle is discarded, even if in_valid = 1.
  2. Empty (main_v = 0): if acc, main takes in_data.
  3. main only, pop, acc: main takes in_data. Back-to-back, 1 item per cycle.
  4. main only, pop, no acc: main_v = 0.
  5. main only, no pop, acc: skid takes in_data; in_ready drops next cycle.
  6. Full (skid_v = 1; acc impossible): if pop, main takes skid_d and skid_v = 0. Otherwise hold.
- Reset values: out_valid = 0, out_data = 0 (when ZERO_ON_FLUSH = 1), in_ready = 1, occupancy = 0.
- Latency: 1 cycle from acc to out_valid. Throughput: 1 item per cycle while out_ready = 1.
- Strict FIFO order; no item is ever duplicated or dropped except by flush/reset.
- out_data stays stable while out_valid = 1 and out_ready = 0.
- out_ready while out_valid = 0 is a don't-care. in_data is ignored when acc = 0.
- Stall: the hazard unit drives out_ready = 0. Occupancy rises to at most 2, then in_ready = 0 backpressures upstream.
- Flush concurrent with pop: the downstream stage has already sampled the item; the block only guarantees that it is empty next cycle.
- Reset asserted mid-stream behaves exactly as flush, and additionally takes priority over flush.

Decomposition:
- Shared package pl_pkg holds the payload width constants: FD_PAYLOAD_W, DE_PAYLOAD_W = 211, EM_PAYLOAD_W, MW_PAYLOAD_W.
- pl_pkg also holds the field offset localparams used by each stage to pack/unpack payloads, e.g. the D/E bundle order RegWrite..selectauipc from MSB down.
- No sub-module. The two slots are simple enough to write inline; packing/unpacking stays at the instantiation site.

Test Plan:
1. Reset: reset = 1 for 2 cycles with in_valid = 1, in_data = 0xDEADBEEF -> out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0 after release.
2. Streaming: out_ready = 1, push 0x1, 0x2, 0x3 on consecutive cycles -> out_data 0x1, 0x2, 0x3 on the following three cycles; occupancy stays 1; in_ready stays 1.
3. Backpressure: out_ready = 0, push 0xA, 0xB, then present 0xC -> occupancy = 2, in_ready = 0, 0xC not accepted. Raise out_ready -> 0xA, 0xB, 0xC emerge in order, none lost.
4. Flush when full: occupancy = 2 (0xA, 0xB), flush = 1 with in_valid = 1 and in_data = 0xC -> next cycle out_valid = 0, occupancy = 0, out_data = 0, in_ready = 1; 0xC never appears.
5. ZERO_ON_FLUSH = 0, WIDTH = 8: flush while holding 0x5A -> out_valid = 0 and out_data = 0x5A.
6. Randomised valid/ready against a reference queue, with random flush at 5%, WIDTH = 211 -> output sequence equals the reference queue and out_data is stable under stall.
